// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//   Front end of the bit-serial CPU. Synchronises and debounces the push
//   button, then uses two button presses to assemble a 16-bit instruction
//   from the DIP-switch byte:
//     first press  : opcode <- ui_in[3:0], low operand nibble <- ui_in[7:4]
//     second press : instr  <- {ui_in, low operand nibble}
//   The completed instruction is offered to cpu_core through a one-entry
//   valid/ready holding register. If a completed instruction cannot be
//   stored, it is dropped and a sticky overflow flag is raised.
//
// Ports
//   clk          in   system clock, all state on rising edge
//   rst_n        in   asynchronous active-low reset
//   ui_in        in   [7:0]  DIP-switch data byte
//   btn_raw      in   raw bouncing push button (high = pressed)
//   abort        in   discard a partially assembled instruction
//   instr_ready  in   consumer takes the held instruction when valid
//   clr_overflow in   clear the overflow flag
//   instr_valid  out  holding register holds an unconsumed instruction
//   opcode       out  [3:0]  held opcode
//   instr        out  [11:0] held operand field {hi byte, lo nibble}
//   phase        out  0 = awaiting first byte, 1 = awaiting second byte
//   overflow     out  sticky: a completed instruction was dropped
//   btn_db       out  debounced button level
// -----------------------------------------------------------------------------
module instr_loader #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  ui_in,
   input  logic        btn_raw,
   input  logic        abort,
   input  logic        instr_ready,
   input  logic        clr_overflow,
   output logic        instr_valid,
   output logic [3:0]  opcode,
   output logic [11:0] instr,
   output logic        phase,
   output logic        overflow,
   output logic        btn_db
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {PH0 = 1'b0, PH1 = 1'b1} phase_t;

   logic             btn_s0, btn_s1;
   logic [CNT_W-1:0] db_cnt;
   logic             btn_db_d;
   logic             press;
   phase_t           state, state_nxt;
   logic             capture_lo, complete, load, drop;
   logic [3:0]       lo_op;
   logic [3:0]       lo_nib;

   // ---------------------------------------------------------------------------
   // Two-flop synchroniser and debounce counter. A level change is accepted
   // only after the synchronised input has differed from btn_db for
   // DEBOUNCE_CYCLES consecutive cycles; any return resets the count.
   // ---------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_s0   <= 1'b0;
         btn_s1   <= 1'b0;
         db_cnt   <= '0;
         btn_db   <= 1'b0;
         btn_db_d <= 1'b0;
      end else begin
         btn_s0   <= btn_raw;
         btn_s1   <= btn_s0;
         btn_db_d <= btn_db;
         if (btn_s1 == btn_db) begin
            db_cnt <= '0;
         end else if (db_cnt == CNT_LAST) begin
            btn_db <= btn_s1;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + CNT_W'(1);
         end
      end
   end

   // One-cycle strobe on the debounced rising edge; releases are ignored.
   assign press = btn_db & ~btn_db_d;

   // ---------------------------------------------------------------------------
   // Assembly FSM: state register / next state / outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= PH0;
      else        state <= state_nxt;
   end

   // NOTE: every signal assigned in a combinational block gets a default
   // first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = PH0;
      end else if (press) begin
         state_nxt = (state == PH0) ? PH1 : PH0;
      end
   end

   // abort takes priority over a press arriving in the same cycle.
   always_comb begin
      phase      = (state == PH1);
      capture_lo = (state == PH0) && press && !abort;
      complete   = (state == PH1) && press && !abort;
   end

   // A completed instruction fits if the slot is empty or is being emptied
   // on this very edge; otherwise it is lost.
   assign load = complete & (~instr_valid | instr_ready);
   assign drop = complete & instr_valid & ~instr_ready;

   // ---------------------------------------------------------------------------
   // First-byte fields, holding register and overflow flag
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_op  <= '0;
         lo_nib <= '0;
      end else if (abort) begin
         lo_op  <= '0;
         lo_nib <= '0;
      end else if (capture_lo) begin
         lo_op  <= ui_in[3:0];
         lo_nib <= ui_in[7:4];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_valid <= 1'b0;
         opcode      <= '0;
         instr       <= '0;
      end else if (load) begin
         instr_valid <= 1'b1;
         opcode      <= lo_op;
         instr       <= {ui_in, lo_nib};
      end else if (instr_valid && instr_ready) begin
         // Data fields keep their last value after consumption.
         instr_valid <= 1'b0;
      end
   end

   // A drop in the same cycle as clr_overflow leaves the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            overflow <= 1'b0;
      else if (drop)         overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
   end

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
//   Self-checking bench for instr_loader with DEBOUNCE_CYCLES = 4.
//   A behavioural model tracks the expected outputs edge by edge; a compare
//   process checks all outputs against it on every falling edge. Directed
//   sequences add literal expectations, followed by a randomized section.
// -----------------------------------------------------------------------------
module tb_instr_loader;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  ui_in = '0;
   logic        btn_raw = 1'b0;
   logic        abort = 1'b0;
   logic        instr_ready = 1'b0;
   logic        clr_overflow = 1'b0;
   logic        instr_valid;
   logic [3:0]  opcode;
   logic [11:0] instr;
   logic        phase;
   logic        overflow;
   logic        btn_db;

   int checks = 0;
   int errors = 0;

   instr_loader #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ui_in        (ui_in),
      .btn_raw      (btn_raw),
      .abort        (abort),
      .instr_ready  (instr_ready),
      .clr_overflow (clr_overflow),
      .instr_valid  (instr_valid),
      .opcode       (opcode),
      .instr        (instr),
      .phase        (phase),
      .overflow     (overflow),
      .btn_db       (btn_db)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model
   //   raw_hist : btn_raw as seen through the two-cycle synchroniser delay
   //   win      : the last D synchronised samples; the debounced level flips
   //              once all of them disagree with it
   //   first    : byte captured by the first press of a pair
   //   hold     : the one-entry holding slot, stored as the full 16-bit word
   // ---------------------------------------------------------------------------
   bit [1:0]  m_raw_hist;
   bit        m_win [D];
   bit        m_db, m_db_prev;
   bit        m_phase;
   bit [7:0]  m_first;
   bit        m_valid;
   bit [15:0] m_word;
   bit        m_ovf;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_raw_hist = '0;
         foreach (m_win[i]) m_win[i] = 1'b0;
         m_db = 0; m_db_prev = 0; m_phase = 0; m_first = '0;
         m_valid = 0; m_word = '0; m_ovf = 0;
      end else begin
         bit        synced, pressed, all_differ, fits;
         bit [15:0] w;
         synced  = m_raw_hist[1];
         pressed = m_db && !m_db_prev;

         for (int i = D - 1; i > 0; i--) m_win[i] = m_win[i-1];
         m_win[0] = synced;
         all_differ = 1;
         for (int i = 0; i < D; i++) if (m_win[i] == m_db) all_differ = 0;
         m_db_prev = m_db;
         if (all_differ) m_db = !m_db;
         m_raw_hist = {m_raw_hist[0], btn_raw};

         fits = !m_valid || instr_ready;
         if (m_valid && instr_ready) m_valid = 0;
         if (clr_overflow) m_ovf = 0;

         if (abort) begin
            m_phase = 0;
         end else if (pressed && !m_phase) begin
            m_first = ui_in;
            m_phase = 1;
         end else if (pressed && m_phase) begin
            m_phase = 0;
            w = {ui_in, m_first};
            if (fits) begin
               m_word  = w;
               m_valid = 1;
            end else begin
               m_ovf = 1;
            end
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         check("cyc_btn_db",      btn_db,      m_db);
         check("cyc_phase",       phase,       m_phase);
         check("cyc_instr_valid", instr_valid, m_valid);
         check("cyc_opcode",      opcode,      m_word[3:0]);
         check("cyc_instr",       instr,       m_word[15:4]);
         check("cyc_overflow",    overflow,    m_ovf);
      end
   end

   // Hold a byte on the switches and press the button cleanly.
   task automatic press_byte(input logic [7:0] b);
      ui_in   = b;
      btn_raw = 1'b1;
      repeat (10) @(negedge clk);
      btn_raw = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_valid",    instr_valid, 0);
      check("rst_opcode",   opcode,      0);
      check("rst_instr",    instr,       0);
      check("rst_phase",    phase,       0);
      check("rst_overflow", overflow,    0);
      check("rst_btn_db",   btn_db,      0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Glitch rejection: 3 high / 1 low, five times
      for (int i = 0; i < 5; i++) begin
         btn_raw = 1'b1;
         repeat (3) @(negedge clk);
         btn_raw = 1'b0;
         @(negedge clk);
         check("bounce_btn_db", btn_db, 0);
      end
      repeat (6) @(negedge clk);
      check("bounce_phase", phase,       0);
      check("bounce_valid", instr_valid, 0);

      // Two-press assembly with exact load latency
      ui_in   = 8'h5A;
      btn_raw = 1'b1;
      repeat (10) @(negedge clk);
      check("t1_phase_after_first", phase, 1);
      btn_raw = 1'b0;
      repeat (10) @(negedge clk);
      ui_in   = 8'hC3;
      btn_raw = 1'b1;
      repeat (6) @(negedge clk);
      check("t1_valid_before_k6", instr_valid, 0);
      check("t1_phase_before_k6", phase,       1);
      @(negedge clk);
      check("t1_valid_at_k6", instr_valid, 1);
      check("t1_phase_at_k6", phase,       0);
      check("t1_opcode",      opcode,      4'hA);
      check("t1_instr",       instr,       12'hC35);
      repeat (3) @(negedge clk);
      btn_raw = 1'b0;
      repeat (10) @(negedge clk);
      check("t1_opcode_held", opcode, 4'hA);
      check("t1_instr_held",  instr,  12'hC35);

      // Overflow while the slot is full, then clear
      press_byte(8'h01);
      press_byte(8'hFF);
      check("t3_overflow", overflow,    1);
      check("t3_valid",    instr_valid, 1);
      check("t3_opcode",   opcode,      4'hA);
      check("t3_instr",    instr,       12'hC35);
      clr_overflow = 1'b1;
      @(negedge clk);
      clr_overflow = 1'b0;
      check("t3_overflow_cleared", overflow, 0);

      // Consume and load on the same edge
      press_byte(8'h01);
      ui_in   = 8'hFF;
      btn_raw = 1'b1;
      repeat (6) @(negedge clk);
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      check("t4_valid",    instr_valid, 1);
      check("t4_opcode",   opcode,      4'h1);
      check("t4_instr",    instr,       12'hFF0);
      check("t4_overflow", overflow,    0);
      btn_raw = 1'b0;
      repeat (10) @(negedge clk);
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      check("t4_consumed",     instr_valid, 0);
      check("t4_opcode_kept",  opcode,      4'h1);

      // Abort discards the first byte
      press_byte(8'h5A);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t5_phase_aborted", phase, 0);
      press_byte(8'h37);
      check("t5_phase", phase,       1);
      check("t5_valid", instr_valid, 0);
      press_byte(8'h00);
      check("t5_opcode", opcode, 4'h7);
      check("t5_instr",  instr,  12'h003);
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;

      // Randomized stimulus against the model
      for (int seg = 0; seg < 70; seg++) begin
         int len;
         btn_raw = ~btn_raw;
         len = $urandom_range(1, 12);
         for (int c = 0; c < len; c++) begin
            ui_in        = 8'($urandom);
            abort        = ($urandom_range(0, 29) == 0);
            instr_ready  = 1'($urandom_range(0, 1));
            clr_overflow = ($urandom_range(0, 19) == 0);
            @(negedge clk);
         end
      end
      abort = 1'b0; instr_ready = 1'b0; clr_overflow = 1'b0; btn_raw = 1'b0;
      repeat (10) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;

      // Asynchronous reset mid-assembly with a full slot
      press_byte(8'h11);
      press_byte(8'h22);
      press_byte(8'h33);
      check("t6_pre_valid", instr_valid, 1);
      check("t6_pre_phase", phase,       1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t6_valid",    instr_valid, 0);
      check("t6_opcode",   opcode,      0);
      check("t6_instr",    instr,       0);
      check("t6_phase",    phase,       0);
      check("t6_overflow", overflow,    0);
      check("t6_btn_db",   btn_db,      0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      press_byte(8'h37);
      check("t6_first_again", phase,       1);
      check("t6_no_valid",    instr_valid, 0);
      press_byte(8'h12);
      check("t6_opcode_new", opcode,      4'h7);
      check("t6_instr_new",  instr,       12'h123);
      check("t6_valid_new",  instr_valid, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
